// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and widths for the AXI-Stream switch output side.
// Holds the arbiter state encoding and the port index width helper.
package axis_sw_pkg;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} arb_state_t;

  localparam int AXIS_SW_ID_WIDTH   = 8;
  localparam int AXIS_SW_USER_WIDTH = 10;
  localparam int AXIS_SW_DATA_WIDTH = 8;

  // A single port still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr,
// searching upward with wrap at N_PORTS.
module rr_arbiter
  import axis_sw_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = idx_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_idx  = '0;
    gnt_vld  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      // Modulo keeps non-power-of-2 port counts in range.
      cand     = (int'(ptr) + i) % N_PORTS;
      cand_idx = IDX_W'(cand);
      if (!gnt_vld && req[cand_idx]) begin
        gnt_idx = cand_idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_arbiter.sv
// N-to-1 packet-locked round-robin AXI-Stream arbiter.
// state | meaning:  IDLE | pick next port (bubble cycle)  LOCK | forward grant port until tlast
module axis_packet_arbiter
  import axis_sw_pkg::*;
#(
  parameter int N_PORTS      = 4,
  parameter int T_DATA_WIDTH = AXIS_SW_DATA_WIDTH,
  parameter int T_USER_WIDTH = AXIS_SW_USER_WIDTH,
  parameter int T_ID_WIDTH   = AXIS_SW_ID_WIDTH,
  localparam int IDX_W       = idx_width(N_PORTS)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [N_PORTS*T_ID_WIDTH-1:0]   s_id_i,
  input  logic [N_PORTS*T_DATA_WIDTH-1:0] s_data_i,
  input  logic [N_PORTS*T_USER_WIDTH-1:0] s_user_i,
  input  logic [N_PORTS-1:0]              s_last_i,
  input  logic [N_PORTS-1:0]              s_valid_i,
  output logic [N_PORTS-1:0]              s_ready_o,
  output logic [T_ID_WIDTH-1:0]           m_id_o,
  output logic [T_DATA_WIDTH-1:0]         m_data_o,
  output logic [T_USER_WIDTH-1:0]         m_user_o,
  output logic                            m_last_o,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic [IDX_W-1:0]                grant_o,
  output logic                            busy_o
);

  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_PORTS - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             locked;
  logic             sel_valid;
  logic             sel_last;

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (s_valid_i),
    .ptr     (rr_ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign locked = (state == LOCK);

  // Constant-base slices per port avoid a variable part-select on the bus.
  always_comb begin
    m_id_o    = '0;
    m_data_o  = '0;
    m_user_o  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    s_ready_o = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (grant == IDX_W'(k)) begin
        m_id_o       = s_id_i[k*T_ID_WIDTH +: T_ID_WIDTH];
        m_data_o     = s_data_i[k*T_DATA_WIDTH +: T_DATA_WIDTH];
        m_user_o     = s_user_i[k*T_USER_WIDTH +: T_USER_WIDTH];
        sel_valid    = s_valid_i[k];
        sel_last     = s_last_i[k];
        s_ready_o[k] = locked & m_ready_i;
      end
    end
    m_valid_o = locked & sel_valid;
    m_last_o  = locked & sel_last;
  end

  assign grant_o = grant;
  assign busy_o  = locked;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      grant  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            grant <= gnt_idx;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (m_valid_o && m_ready_i && m_last_o) begin
            state  <= IDLE;
            rr_ptr <= (grant == LAST_PORT) ? '0 : grant + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
